// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-SRC control sequencer: opcodes, FSM states,
// instruction classes and the control-strobe bundle.
package cpu_pkg;

  localparam int unsigned OPW_DEF = 5;
  localparam int unsigned IR_W    = 32;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [5:0] {
    RESET_S, FETCH0, FETCH1, FETCH2,
    ALU_T3, ALU_T4, ALUI_T4, ALU_T5,
    NEG_T3, NEG_T4,
    LD_T3, LD_T4, LD_T5, LD_T6, LD_T7, LDI_T5,
    ST_T6, ST_T7,
    BR_T3, BR_T4, BR_T5, BR_T6,
    JR_T3, IN_T3, OUT_T3, MFHI_T3, MFLO_T3, NOP_T3,
    MD_T3, MD_T4, MD_T5, MD_T6,
    HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_NEG, CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR,
    CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_MULDIV, CL_NOP, CL_HALT
  } iclass_e;

  typedef struct packed {
    logic hi_in;
    logic lo_in;
    logic pc_in;
    logic mdr_in;
    logic z_in;
    logic y_in;
    logic mar_in;
    logic ir_in;
    logic con_in;
    logic outport_in;
    logic hi_out;
    logic lo_out;
    logic zhi_out;
    logic zlo_out;
    logic pc_out;
    logic mdr_out;
    logic inport_out;
    logic c_out;
    logic y_out;
    logic ba_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic read;
    logic write;
    logic inc_pc;
    logic run;
    logic clear;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath connection: datapath feedback in, control strobes out.
interface control_unit_if #(
  parameter int unsigned OPW = 5
);
  logic            Stop;
  logic [31:0]     IR;
  logic            CON;
  logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, BAout;
  logic Gra, Grb, Grc, Rin, Rout;
  logic Read, Write, IncPC;
  logic [OPW-1:0]  AluOp;
  logic            Run;
  logic            Clear;

  modport master (
    input  Stop, IR, CON,
    output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, BAout,
    output Gra, Grb, Grc, Rin, Rout, Read, Write, IncPC, AluOp, Run, Clear
  );

  modport slave (
    output Stop, IR, CON,
    input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, BAout,
    input  Gra, Grb, Grc, Rin, Rout, Read, Write, IncPC, AluOp, Run, Clear
  );
endinterface

// File: rtl/cu_decode.sv
// Opcode -> instruction-class decoder. CU_MULDIV_EN enables the mul/div
// sequence; otherwise mul and div decode as nop.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_e    class_o
);

  always_comb begin
    class_o = CL_NOP;
    case (opcode_i)
      OP_LD:   class_o = CL_LD;
      OP_LDI:  class_o = CL_LDI;
      OP_ST:   class_o = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:
               class_o = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:
               class_o = CL_IMM;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:
               class_o = CL_MULDIV;
`else
      OP_MUL, OP_DIV:
               class_o = CL_NOP;
`endif
      OP_NEG, OP_NOT:
               class_o = CL_NEG;
      OP_BR:   class_o = CL_BR;
      OP_JR:   class_o = CL_JR;
      OP_IN:   class_o = CL_IN;
      OP_OUT:  class_o = CL_OUT;
      OP_MFHI: class_o = CL_MFHI;
      OP_MFLO: class_o = CL_MFLO;
      OP_HALT: class_o = CL_HALT;
      default: class_o = CL_NOP;   // jal, nop and undefined opcodes
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the mini-SRC datapath: one T-state per clock,
// all strobes registered. mul/div sequencing depends on CU_MULDIV_EN (see cu_decode).
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  state_e         state_q, state_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [4:0]     opcode;
  iclass_e        iclass;
  logic           unused_ir;

  assign opcode    = bus.IR[IR_W-1 -: 5];
  assign unused_ir = ^bus.IR[IR_W-6:0];

  cu_decode u_decode (
    .opcode_i (opcode),
    .class_o  (iclass)
  );

  // Next-state; every entry into FETCH0 is where Stop gets sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_S: state_d = FETCH0;
      FETCH0:  state_d = FETCH1;
      FETCH1:  state_d = FETCH2;
      FETCH2: begin
        case (iclass)
          CL_ALU, CL_IMM: state_d = ALU_T3;
          CL_NEG:         state_d = NEG_T3;
          CL_LD, CL_LDI, CL_ST:
                          state_d = LD_T3;
          CL_BR:          state_d = BR_T3;
          CL_JR:          state_d = JR_T3;
          CL_IN:          state_d = IN_T3;
          CL_OUT:         state_d = OUT_T3;
          CL_MFHI:        state_d = MFHI_T3;
          CL_MFLO:        state_d = MFLO_T3;
          CL_MULDIV:      state_d = MD_T3;
          CL_HALT:        state_d = HALT;
          default:        state_d = NOP_T3;
        endcase
      end
      ALU_T3:  state_d = (iclass == CL_IMM) ? ALUI_T4 : ALU_T4;
      ALU_T4, ALUI_T4:
               state_d = ALU_T5;
      NEG_T3:  state_d = NEG_T4;
      LD_T3:   state_d = LD_T4;
      LD_T4:   state_d = (iclass == CL_LDI) ? LDI_T5 : LD_T5;
      LD_T5:   state_d = (iclass == CL_ST) ? ST_T6 : LD_T6;
      LD_T6:   state_d = LD_T7;
      ST_T6:   state_d = ST_T7;
      BR_T3:   state_d = BR_T4;
      BR_T4:   state_d = BR_T5;
      BR_T5:   state_d = bus.CON ? BR_T6 : FETCH0;
      MD_T3:   state_d = MD_T4;
      MD_T4:   state_d = MD_T5;
      MD_T5:   state_d = MD_T6;
      HALT:    state_d = HALT;
      default: state_d = FETCH0;
    endcase
    if ((state_d == FETCH0) && bus.Stop) begin
      state_d = HALT;
    end
  end

  // Strobes for the state being entered, so the registered outputs track state_q.
  always_comb begin
    ctrl_d     = '0;
    alu_op_d   = OPW'(ALU_ADD);
    ctrl_d.run = (state_d != HALT) && (state_d != RESET_S);
    case (state_d)
      RESET_S: ctrl_d.clear = 1'b1;
      FETCH0:  begin ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1;
                     ctrl_d.inc_pc = 1'b1; ctrl_d.z_in = 1'b1; end
      FETCH1:  begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; ctrl_d.pc_in = 1'b1; end
      FETCH2:  begin ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1; end
      ALU_T3:  begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
      ALU_T4:  begin ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1;
                     alu_op_d = OPW'(opcode); end
      ALUI_T4: begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1;
                     alu_op_d = OPW'(opcode); end
      ALU_T5, NEG_T4, LDI_T5:
               begin ctrl_d.zlo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
      NEG_T3:  begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1;
                     alu_op_d = OPW'(opcode); end
      LD_T3:   begin ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.y_in = 1'b1; end
      LD_T4, BR_T5:
               begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; end
      LD_T5:   begin ctrl_d.zlo_out = 1'b1; ctrl_d.mar_in = 1'b1; end
      LD_T6:   begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
      LD_T7:   begin ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
      ST_T6:   begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.mdr_in = 1'b1; end
      ST_T7:   ctrl_d.write = 1'b1;
      BR_T3:   begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.con_in = 1'b1; end
      BR_T4:   begin ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1; end
      BR_T6:   begin ctrl_d.zlo_out = 1'b1; ctrl_d.pc_in = 1'b1; end
      JR_T3:   begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
      IN_T3:   begin ctrl_d.inport_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
      OUT_T3:  begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.outport_in = 1'b1; end
      MFHI_T3: begin ctrl_d.hi_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
      MFLO_T3: begin ctrl_d.lo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
      MD_T3:   begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
      MD_T4:   begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1;
                     alu_op_d = OPW'(opcode); end
      MD_T5:   begin ctrl_d.zlo_out = 1'b1; ctrl_d.lo_in = 1'b1; end
      MD_T6:   begin ctrl_d.zhi_out = 1'b1; ctrl_d.hi_in = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= RESET_S;
      ctrl_q   <= '{clear: 1'b1, default: 1'b0};
      alu_op_q <= OPW'(ALU_ADD);
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign bus.HIin      = ctrl_q.hi_in;
  assign bus.LOin      = ctrl_q.lo_in;
  assign bus.PCin      = ctrl_q.pc_in;
  assign bus.MDRin     = ctrl_q.mdr_in;
  assign bus.Zin       = ctrl_q.z_in;
  assign bus.Yin       = ctrl_q.y_in;
  assign bus.MARin     = ctrl_q.mar_in;
  assign bus.IRin      = ctrl_q.ir_in;
  assign bus.CONin     = ctrl_q.con_in;
  assign bus.OUTPORTin = ctrl_q.outport_in;
  assign bus.HIout     = ctrl_q.hi_out;
  assign bus.LOout     = ctrl_q.lo_out;
  assign bus.ZHIout    = ctrl_q.zhi_out;
  assign bus.ZLOout    = ctrl_q.zlo_out;
  assign bus.PCout     = ctrl_q.pc_out;
  assign bus.MDRout    = ctrl_q.mdr_out;
  assign bus.INPORTout = ctrl_q.inport_out;
  assign bus.Cout      = ctrl_q.c_out;
  assign bus.Yout      = ctrl_q.y_out;
  assign bus.BAout     = ctrl_q.ba_out;
  assign bus.Gra       = ctrl_q.gra;
  assign bus.Grb       = ctrl_q.grb;
  assign bus.Grc       = ctrl_q.grc;
  assign bus.Rin       = ctrl_q.r_in;
  assign bus.Rout      = ctrl_q.r_out;
  assign bus.Read      = ctrl_q.read;
  assign bus.Write     = ctrl_q.write;
  assign bus.IncPC     = ctrl_q.inc_pc;
  assign bus.AluOp     = alu_op_q;
  assign bus.Run       = ctrl_q.run;
  assign bus.Clear     = ctrl_q.clear;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe scoreboard driven by an
// instruction table, plus reset, Stop and halt sequences. Honours CU_MULDIV_EN.
module tb_control_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  control_unit_if #(.OPW(5)) bus ();

  control_unit #(.OPW(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  localparam int HIIN = 27, LOIN = 26, PCIN = 25, MDRIN = 24, ZIN = 23, YIN = 22;
  localparam int MARIN = 21, IRIN = 20, CONIN = 19, OUTIN = 18, HIOUT = 17, LOOUT = 16;
  localparam int ZHIOUT = 15, ZLOOUT = 14, PCOUT = 13, MDROUT = 12, INOUT = 11;
  localparam int COUT = 10, YOUT = 9, BAOUT = 8, GRA = 7, GRB = 6, GRC = 5;
  localparam int RIN = 4, ROUT = 3, READ = 2, WRITE = 1, INCPC = 0;
  localparam logic [4:0] ADD = 5'b00011;

  typedef struct packed {
    logic [27:0] mask;
    logic [4:0]  alu;
    logic        run;
    logic        clear;
  } exp_t;

  typedef struct packed {
    logic [31:0] ir;
    logic        con;
  } vec_t;

  exp_t q[$];
  vec_t vecs[24];
  int   checks = 0;
  int   errors = 0;
  logic [27:0] act_mask;

  assign act_mask = {bus.HIin, bus.LOin, bus.PCin, bus.MDRin, bus.Zin, bus.Yin,
                     bus.MARin, bus.IRin, bus.CONin, bus.OUTPORTin, bus.HIout,
                     bus.LOout, bus.ZHIout, bus.ZLOout, bus.PCout, bus.MDRout,
                     bus.INPORTout, bus.Cout, bus.Yout, bus.BAout, bus.Gra, bus.Grb,
                     bus.Grc, bus.Rin, bus.Rout, bus.Read, bus.Write, bus.IncPC};

  function automatic logic [27:0] b(input int idx);
    return 28'(1) << idx;
  endfunction

  task automatic push(input logic [27:0] m, input logic [4:0] a);
    exp_t e;
    e.mask = m; e.alu = a; e.run = 1'b1; e.clear = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_halt(input int n);
    exp_t e;
    e.mask = '0; e.alu = ADD; e.run = 1'b0; e.clear = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic check(input string tag, input int step, input exp_t e);
    checks++;
    if (act_mask !== e.mask || bus.AluOp !== e.alu || bus.Run !== e.run ||
        bus.Clear !== e.clear) begin
      errors++;
      $display("FAIL %s step %0d: got mask=%h alu=%b run=%b clr=%b, want mask=%h alu=%b run=%b clr=%b",
               tag, step, act_mask, bus.AluOp, bus.Run, bus.Clear,
               e.mask, e.alu, e.run, e.clear);
    end
  endtask

  // Reference sequence for one instruction, written straight from the step tables.
  task automatic push_instr(input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    push(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), ADD);
    push(b(READ) | b(MDRIN) | b(PCIN), ADD);
    push(b(MDROUT) | b(IRIN), ADD);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        push(b(GRB) | b(ROUT) | b(YIN), ADD);
        push(b(GRC) | b(ROUT) | b(ZIN), op);
        push(b(ZLOOUT) | b(GRA) | b(RIN), ADD);
      end
      5'd12, 5'd13, 5'd14: begin
        push(b(GRB) | b(ROUT) | b(YIN), ADD);
        push(b(COUT) | b(ZIN), op);
        push(b(ZLOOUT) | b(GRA) | b(RIN), ADD);
      end
      5'd17, 5'd18: begin
        push(b(GRB) | b(ROUT) | b(ZIN), op);
        push(b(ZLOOUT) | b(GRA) | b(RIN), ADD);
      end
      5'd0, 5'd1, 5'd2: begin
        push(b(GRB) | b(BAOUT) | b(YIN), ADD);
        push(b(COUT) | b(ZIN), ADD);
        if (op == 5'd1) push(b(ZLOOUT) | b(GRA) | b(RIN), ADD);
        else begin
          push(b(ZLOOUT) | b(MARIN), ADD);
          if (op == 5'd0) begin
            push(b(READ) | b(MDRIN), ADD);
            push(b(MDROUT) | b(GRA) | b(RIN), ADD);
          end else begin
            push(b(GRA) | b(ROUT) | b(MDRIN), ADD);
            push(b(WRITE), ADD);
          end
        end
      end
      5'd19: begin
        push(b(GRA) | b(ROUT) | b(CONIN), ADD);
        push(b(PCOUT) | b(YIN), ADD);
        push(b(COUT) | b(ZIN), ADD);
        if (con) push(b(ZLOOUT) | b(PCIN), ADD);
      end
      5'd20: push(b(GRA) | b(ROUT) | b(PCIN), ADD);
      5'd22: push(b(INOUT) | b(GRA) | b(RIN), ADD);
      5'd23: push(b(GRA) | b(ROUT) | b(OUTIN), ADD);
      5'd24: push(b(HIOUT) | b(GRA) | b(RIN), ADD);
      5'd25: push(b(LOOUT) | b(GRA) | b(RIN), ADD);
`ifdef CU_MULDIV_EN
      5'd15, 5'd16: begin
        push(b(GRA) | b(ROUT) | b(YIN), ADD);
        push(b(GRB) | b(ROUT) | b(ZIN), op);
        push(b(ZLOOUT) | b(LOIN), ADD);
        push(b(ZHIOUT) | b(HIIN), ADD);
      end
`endif
      5'd27: push_halt(20);
      default: push('0, ADD);
    endcase
  endtask

  // Pop and compare up to n_max cycles; Stop is raised/dropped after given steps.
  task automatic drain(input string tag, input int n_max, input int set_at, input int clr_at);
    exp_t e;
    for (int j = 0; j < n_max && q.size() > 0; j++) begin
      @(negedge Clock);
      e = q.pop_front();
      check(tag, j, e);
      if (j == set_at) bus.Stop = 1'b1;
      if (j == clr_at) bus.Stop = 1'b0;
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con);
    bus.IR  = ir;
    bus.CON = con;
    push_instr(ir, con);
    drain(tag, 64, -1, -1);
  endtask

  // Asynchronous reset applied mid-cycle, checked before and after a clock edge.
  task automatic reset_seq(input string tag);
    exp_t r;
    r.mask = '0; r.alu = ADD; r.run = 1'b0; r.clear = 1'b1;
    q.delete();
    #2 Reset = 1'b1;
    #1 check({tag, "_async"}, 0, r);
    @(negedge Clock);
    check({tag, "_hold"}, 1, r);
    Reset = 1'b0;
  endtask

  initial begin
    bus.Stop = 1'b0;
    bus.IR   = {5'b11010, 27'h0};
    bus.CON  = 1'b0;

    vecs[0]  = '{ir: {5'b00011, 27'h0123456}, con: 1'b0};
    vecs[1]  = '{ir: {5'b00100, 27'h7654321}, con: 1'b0};
    vecs[2]  = '{ir: {5'b00101, 27'h0}, con: 1'b1};
    vecs[3]  = '{ir: {5'b00111, 27'h1}, con: 1'b0};
    vecs[4]  = '{ir: {5'b01011, 27'h2}, con: 1'b0};
    vecs[5]  = '{ir: {5'b01100, 27'h3}, con: 1'b0};
    vecs[6]  = '{ir: {5'b01110, 27'h4}, con: 1'b0};
    vecs[7]  = '{ir: {5'b10001, 27'h5}, con: 1'b0};
    vecs[8]  = '{ir: {5'b10010, 27'h6}, con: 1'b0};
    vecs[9]  = '{ir: {5'b00000, 27'h7}, con: 1'b0};
    vecs[10] = '{ir: {5'b00001, 27'h8}, con: 1'b0};
    vecs[11] = '{ir: {5'b00010, 27'h9}, con: 1'b0};
    vecs[12] = '{ir: {5'b10011, 27'hA}, con: 1'b1};
    vecs[13] = '{ir: {5'b10011, 27'hB}, con: 1'b0};
    vecs[14] = '{ir: {5'b10100, 27'hC}, con: 1'b0};
    vecs[15] = '{ir: {5'b10110, 27'hD}, con: 1'b0};
    vecs[16] = '{ir: {5'b10111, 27'hE}, con: 1'b0};
    vecs[17] = '{ir: {5'b11000, 27'hF}, con: 1'b0};
    vecs[18] = '{ir: {5'b11001, 27'h10}, con: 1'b0};
    vecs[19] = '{ir: {5'b11010, 27'h11}, con: 1'b0};
    vecs[20] = '{ir: {5'b10101, 27'h12}, con: 1'b0};
    vecs[21] = '{ir: {5'b11110, 27'h13}, con: 1'b0};
    vecs[22] = '{ir: {5'b10000, 27'h14}, con: 1'b0};
    vecs[23] = '{ir: {5'b01111, 27'h15}, con: 1'b1};

    #1;
    reset_seq("power_on");

    for (int i = 0; i < 24; i++) begin
      run_instr($sformatf("vec%0d_op%0d", i, vecs[i].ir[31:27]), vecs[i].ir, vecs[i].con);
    end

    // Reset during ld T4: strobes drop at once, fetch resumes after release.
    bus.IR = {5'b00000, 27'h0};
    push_instr(bus.IR, 1'b0);
    drain("ld_abort", 5, -1, -1);
    reset_seq("ld_reset");
    run_instr("after_reset_nop", {5'b11010, 27'h0}, 1'b0);

    // Stop pulse during execute that is gone before the next fetch is ignored.
    bus.IR = {5'b00011, 27'h0};
    push_instr(bus.IR, 1'b0);
    drain("stop_pulse", 64, 1, 4);
    run_instr("after_pulse_nop", {5'b11010, 27'h0}, 1'b0);

    // Stop held at the edge into FETCH0 halts; only Reset leaves HALT.
    bus.IR = {5'b00011, 27'h0};
    push_instr(bus.IR, 1'b0);
    drain("stop_halt_add", 64, 5, -1);
    push_halt(20);
    drain("stop_halt", 64, -1, 2);
    reset_seq("stop_recover");
    run_instr("after_stop_nop", {5'b11010, 27'h0}, 1'b0);

    // halt instruction, then recovery.
    run_instr("halt", {5'b11011, 27'h0}, 1'b0);
    reset_seq("halt_recover");
    run_instr("after_halt_add", {5'b00100, 27'h0}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the mini-SRC datapath. It decodes the instruction register (IR) and drives every datapath control strobe, one micro-step (T-state) per clock, covering fetch and execute for the supported instruction set. It sits directly upstream of `datapath` and replaces bench-driven control sequencing. The only datapath feedback it consumes is `IR` and the branch flag `CON`.

## Interface
- `OPW`, default 5: opcode width, taken from IR[31:27].
- `Clock`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `Stop`, in, 1: halt request, sampled at fetch start.
- `IR`, in, 32: instruction register contents.
- `CON`, in, 1: branch-condition flip-flop output.
- Register loads, out, 1 each: `HIin` `LOin` `PCin` `MDRin` `Zin` `Yin` `MARin` `IRin` `CONin` `OUTPORTin`.
- Bus drivers, out, 1 each: `HIout` `LOout` `ZHIout` `ZLOout` `PCout` `MDRout` `INPORTout` `Cout` `Yout` `BAout`.
- Register-file select, out, 1 each: `Gra` `Grb` `Grc` `Rin` `Rout`.
- Memory and PC, out, 1 each: `Read` `Write` `IncPC`.
- `AluOp`, out, OPW: ALU operation. It equals the opcode during ALU steps and is ADD (00011) otherwise.
- `Run`, out, 1: 1 while executing, 0 in HALT.
- `Clear`, out, 1: 1 during RESET_S.

## Operation
- Moore FSM. All outputs are registered and are decoded from the current state only.
- **Reset:** asynchronous `Reset` forces RESET_S. All strobes are 0, `AluOp`=ADD, `Run`=0, `Clear`=1. The first clock after release enters FETCH0 with `Run`=1.
- **Fetch:**
  - FETCH0: `PCout` `MARin` `IncPC` `Zin`. If `Stop`=1 on entry, go to HALT instead.
  - FETCH1: `Read` `MDRin` `PCin`.
  - FETCH2: `MDRout` `IRin`.
  - The next state is chosen by IR[31:27].
- **ALU register ops** (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: `Grb` `Rout` `Yin`.
  - T4: `Grc` `Rout` `Zin`, `AluOp`=opcode.
  - T5: `ZLOout` `Gra` `Rin`.
- **ALU immediate ops** (addi, andi, ori): same as register ops, except T4 uses `Cout` in place of `Grc` `Rout`.
- **neg, not:**
  - T3: `Grb` `Rout` `Zin`, `AluOp`=opcode.
  - T4: `ZLOout` `Gra` `Rin`.
- **ld:**
  - T3: `Grb` `BAout` `Yin`.
  - T4: `Cout` `Zin`.
  - T5: `ZLOout` `MARin`.
  - T6: `Read` `MDRin`.
  - T7: `MDRout` `Gra` `Rin`.
- **ldi:** T3 and T4 as ld, then T5: `ZLOout` `Gra` `Rin`.
- **st:**
  - T3 to T5 as ld.
  - T6: `Gra` `Rout` `MDRin` (with `Read`=0, MDR loads from the bus).
  - T7: `Write`.
- **br:**
  - T3: `Gra` `Rout` `CONin`.
  - T4: `PCout` `Yin`.
  - T5: `Cout` `Zin`.
  - At the end of T5: if `CON`=1 go to BR_T6 (`ZLOout` `PCin`), otherwise go to FETCH0.
- **Single-step ops:**
  - jr: T3 `Gra` `Rout` `PCin`.
  - in: T3 `INPORTout` `Gra` `Rin`.
  - out: T3 `Gra` `Rout` `OUTPORTin`.
  - mfhi: T3 `HIout` `Gra` `Rin`.
  - mflo: T3 `LOout` `Gra` `Rin`.
  - nop: T3 with no strobes.
- Every instruction's last step returns to FETCH0.
- **halt:** enter HALT, with `Run`=0 and all strobes 0. HALT is left only by `Reset`.
- **Undefined opcodes** execute as nop.
- **Opcodes:**
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - addi 01100, andi 01101, ori 01110
  - div 01111, mul 10000, neg 10001, not 10010
  - br 10011, jr 10100, jal 10101 (executes as nop)
  - in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011

## Timing
- One state per clock. Each strobe is high for exactly one full cycle.
- Two states never overlap, and no strobe glitches between states.
- Instruction cycle counts (fetch + execute):
  - ALU register, ALU immediate, ldi: 6.
  - neg, not: 5.
  - ld, st: 8.
  - br taken: 7. br not taken: 6.
  - Single-step ops: 4.
  - mul, div: 7.
- `Stop` is sampled only on the FETCH0 edge. A `Stop` pulse during execute is ignored unless it is still high at the next FETCH0.
- `Reset` mid-instruction aborts immediately, with no partial `Write` or `Rin` completion.
- `CON` is used only at the T5 to T6 edge of br.

## Configuration
- `CU_MULDIV_EN` defined:
  - T3: `Gra` `Rout` `Yin`.
  - T4: `Grb` `Rout` `Zin`, `AluOp`=opcode.
  - T5: `ZLOout` `LOin`.
  - T6: `ZHIout` `HIin`.
- `CU_MULDIV_EN` undefined: mul and div execute as nop, taking 4 cycles with no strobes.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams;
  - the state enum (RESET_S, FETCH0-2, per-class T-states, BR_T6, HALT);
  - ALU_ADD.
- One natural sub-module: `cu_decode`, a combinational decoder from opcode to instruction class. The FSM and output registers stay in `control_unit`.

## Test plan
- **Reset:** assert `Reset` mid-ld. Required: all strobes 0 and `Clear`=1 asynchronously, `Run`=1 one clock after release, then FETCH0 strobes.
- **add (IR=0x18000000 | fields):** required: 3 fetch cycles, then `Grb`/`Rout`/`Yin`, then `Grc`/`Rout`/`Zin` with `AluOp`=00011, then `ZLOout`/`Gra`/`Rin`, then FETCH0. Total 6 cycles.
- **br, CON=1:** required: ends with BR_T6 (`ZLOout` `PCin`), 7 cycles.
- **br, CON=0:** required: FETCH0 follows T5, 6 cycles, and `PCin` never rises after FETCH1.
- **st:** required: `Write` high for exactly 1 cycle at step 8, preceded by `Gra`/`Rout`/`MDRin` with `Read`=0.
- **mul with and without `CU_MULDIV_EN`:** required: with the macro, `LOin` then `HIin` at cycles 6 and 7. Without it, 4 cycles and no strobes.
- **halt, or Stop=1 at FETCH0:** required: `Run`=0 and all strobes 0 for 20 cycles, recovering only on `Reset`.
